// File: rtl/reg_arb.sv
// Two-master round-robin arbiter in front of a single register slave.
// One transaction outstanding at a time; a silent slave is aborted after TIMEOUT wait cycles.
module reg_arb #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [7:0]  m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [7:0]  m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        reg_req,
   output logic        reg_wr,
   output logic [7:0]  reg_addr,
   output logic [31:0] reg_wdata,
   input  logic        reg_ack,
   input  logic [31:0] reg_rdata,
   output logic        busy,
   output logic        grant,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   // Handshake: masters hold mN_req with a stable command until they sample
   // mN_ack (one-cycle pulse); the slave sees a one-cycle reg_req and answers
   // with a one-cycle reg_ack carrying reg_rdata, honoured only in WAIT.

   logic [1:0]  state;
   logic [7:0]  wait_cnt;
   logic        last_m1;
   logic        pick_m1;
   logic        done;
   logic [31:0] done_rdata;
   logic        done_err;

   // Tie goes to whichever master was not served last.
   always_comb begin
      pick_m1 = m1_req && (!m0_req || !last_m1);
   end

   always_comb begin
      done       = 1'b0;
      done_rdata = reg_rdata;
      done_err   = 1'b0;
      if (state == WAIT) begin
         if (reg_ack) begin
            done = 1'b1;
         end else if (wait_cnt == LAST_WAIT) begin
            done       = 1'b1;
            done_rdata = 32'hFFFF_FFFF;
            done_err   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= 8'd0;
         last_m1   <= 1'b1;
         grant     <= 1'b0;
         reg_req   <= 1'b0;
         reg_wr    <= 1'b0;
         reg_addr  <= 8'd0;
         reg_wdata <= 32'd0;
         m0_ack    <= 1'b0;
         m0_err    <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_ack    <= 1'b0;
         m1_err    <= 1'b0;
         m1_rdata  <= 32'd0;
      end else begin
         reg_req <= 1'b0;
         m0_ack  <= 1'b0;
         m0_err  <= 1'b0;
         m1_ack  <= 1'b0;
         m1_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  grant     <= pick_m1;
                  last_m1   <= pick_m1;
                  reg_wr    <= pick_m1 ? m1_wr    : m0_wr;
                  reg_addr  <= pick_m1 ? m1_addr  : m0_addr;
                  reg_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                  reg_req   <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= 8'd0;
               state    <= WAIT;
            end
            WAIT: begin
               if (done) begin
                  if (grant) begin
                     m1_ack   <= 1'b1;
                     m1_rdata <= done_rdata;
                     m1_err   <= done_err;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_rdata <= done_rdata;
                     m0_err   <= done_err;
                  end
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_reg_arb.sv
// Directed bench for reg_arb: a vector table of single transactions plus
// hand-written sequences for ties, timeout with late ack, reset mid-wait and back-to-back.
module tb_reg_arb;

   localparam int TIMEOUT = 16;
   localparam int NEVER   = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_wr = 1'b0;
   logic [7:0]  m0_addr = 8'd0;
   logic [31:0] m0_wdata = 32'd0;
   logic        m0_ack, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0, m1_wr = 1'b0;
   logic [7:0]  m1_addr = 8'd0;
   logic [31:0] m1_wdata = 32'd0;
   logic        m1_ack, m1_err;
   logic [31:0] m1_rdata;
   logic        reg_req, reg_wr;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_ack = 1'b0;
   logic [31:0] reg_rdata = 32'd0;
   logic        busy, grant;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   reg_arb #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_ack(reg_ack), .reg_rdata(reg_rdata),
      .busy(busy), .grant(grant), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic mack(input int m);
      return (m == 0) ? m0_ack : m1_ack;
   endfunction

   function automatic logic merr(input int m);
      return (m == 0) ? m0_err : m1_err;
   endfunction

   function automatic logic [31:0] mrdata(input int m);
      return (m == 0) ? m0_rdata : m1_rdata;
   endfunction

   // continuous protocol monitor, sampled on the falling edge
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         check("reg_req_adjacent", reg_req & prev_req, 0);
         check("both_acks", m0_ack & m1_ack, 0);
         check("m0_err_without_ack", m0_err & ~m0_ack, 0);
         check("m1_err_without_ack", m1_err & ~m1_ack, 0);
      end
      prev_req = reg_req;
   end

   // driver tasks
   task automatic set_master(input int m, input logic req, input logic wr,
                             input logic [7:0] addr, input logic [31:0] wdata);
      if (m == 0) begin
         m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   // Waits for the issue, plays the slave (ack after dly WAIT cycles), and
   // returns on the tick where the granted master's ack is visible.
   task automatic serve(input int m, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input int dly, input logic [31:0] srd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_issue, input int exp_lat);
      int  cnt;
      int  k;
      bit  got;
      cnt = 0;
      while (!reg_req && cnt < 8) begin
         tick();
         cnt++;
      end
      check("issue_latency", cnt, exp_issue);
      if (!reg_req) return;
      check("grant", {31'd0, grant}, m);
      check("reg_cmd", {23'd0, reg_wr, reg_addr}, {23'd0, wr, addr});
      check("reg_wdata", reg_wdata, wdata);
      check("busy_issue", {31'd0, busy}, 1);
      tick();
      check("reg_req_single", {31'd0, reg_req}, 0);
      k   = 0;
      got = 1'b0;
      while (!got && k < 40) begin
         reg_ack   = (k == dly);
         reg_rdata = (k == dly) ? srd : 32'hBAD0_0000 + k;
         tick();
         k++;
         reg_ack = 1'b0;
         got     = mack(m);
      end
      check("ack_seen", {31'd0, got}, 1);
      if (!got) return;
      check("ack_latency", 2 + k, exp_lat);
      check("rdata", mrdata(m), exp_rd);
      check("err", {31'd0, merr(m)}, {31'd0, exp_err});
      check("other_ack", {31'd0, mack(1 - m)}, 0);
      check("cmd_hold", {23'd0, reg_wr, reg_addr}, {23'd0, wr, addr});
   endtask

   typedef struct {
      int          m;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          dly;
      logic [31:0] srd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   task automatic do_txn(input vec_t v);
      set_master(v.m, 1'b1, v.wr, v.addr, v.wdata);
      serve(v.m, v.wr, v.addr, v.wdata, v.dly, v.srd, v.exp_rd, v.exp_err, 1, v.exp_lat);
      set_master(v.m, 1'b0, v.wr, v.addr, v.wdata);
      tick();
      check("ack_after", {31'd0, mack(v.m)}, 0);
      check("err_after", {31'd0, merr(v.m)}, 0);
      check("rdata_hold", mrdata(v.m), v.exp_rd);
      check("busy_idle", {31'd0, busy}, 0);
      check("grant_hold", {31'd0, grant}, v.m);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{0, 1'b0, 8'h18, 32'h0000_0000, 0,  32'h0000_0003, 32'h0000_0003, 1'b0, 3};
      vecs[1] = '{1, 1'b1, 8'h14, 32'h0020_0040, 0,  32'h0000_0000, 32'h0000_0000, 1'b0, 3};
      vecs[2] = '{0, 1'b1, 8'h04, 32'hA5A5_A5A5, 2,  32'h0000_0011, 32'h0000_0011, 1'b0, 5};
      vecs[3] = '{1, 1'b0, 8'hFF, 32'h1111_2222, 7,  32'h1234_5678, 32'h1234_5678, 1'b0, 10};
      vecs[4] = '{0, 1'b0, 8'h00, 32'h0000_0000, 15, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 18};
      vecs[5] = '{1, 1'b0, 8'h80, 32'h0000_0000, 16, 32'h0BAD_0BAD, 32'hFFFF_FFFF, 1'b1, 18};

      // reset state
      tick();
      tick();
      check("rst_ctl", {22'd0, reg_req, reg_wr, busy, grant, m0_ack, m1_ack, m0_err, m1_err, dbg_state}, 0);
      check("rst_addr", {24'd0, reg_addr}, 0);
      check("rst_wdata", reg_wdata, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      check("rst_m1_rdata", m1_rdata, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) do_txn(vecs[i]);

      // tie after reset: both held, expect m0, m1, m0, m1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_master(0, 1'b1, 1'b0, 8'h10, 32'h0);
      set_master(1, 1'b1, 1'b0, 8'h20, 32'h0);
      serve(0, 1'b0, 8'h10, 32'h0, 0, 32'h0000_0A00, 32'h0000_0A00, 1'b0, 1, 3);
      serve(1, 1'b0, 8'h20, 32'h0, 0, 32'h0000_0B01, 32'h0000_0B01, 1'b0, 2, 3);
      serve(0, 1'b0, 8'h10, 32'h0, 1, 32'h0000_0A02, 32'h0000_0A02, 1'b0, 2, 4);
      serve(1, 1'b0, 8'h20, 32'h0, 0, 32'h0000_0B03, 32'h0000_0B03, 1'b0, 2, 3);
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick();

      // timeout, late ack discarded, then a clean m1 read
      set_master(0, 1'b1, 1'b0, 8'h30, 32'h0);
      serve(0, 1'b0, 8'h30, 32'h0, NEVER, 32'h0, 32'hFFFF_FFFF, 1'b1, 1, TIMEOUT + 2);
      m0_req = 1'b0;
      tick();
      tick();
      tick();
      reg_ack   = 1'b1;
      reg_rdata = 32'hDEAD_BEEF;
      tick();
      reg_ack   = 1'b0;
      check("late_ack_busy", {31'd0, busy}, 0);
      tick();
      check("late_ack_no_m0_ack", {31'd0, m0_ack}, 0);
      check("late_m0_rdata_hold", m0_rdata, 32'hFFFF_FFFF);
      do_txn('{1, 1'b0, 8'h34, 32'h0, 0, 32'h0000_0077, 32'h0000_0077, 1'b0, 3});

      // reset mid-WAIT on an m0 transaction; afterwards a tie must go to m0
      set_master(0, 1'b1, 1'b0, 8'h40, 32'h5555_0000);
      tick();
      tick();
      tick();
      check("pre_rst_busy", {31'd0, busy}, 1);
      rst = 1'b1;
      #1;
      check("wait_rst_ctl", {22'd0, reg_req, reg_wr, busy, grant, m0_ack, m1_ack, m0_err, m1_err, dbg_state}, 0);
      check("wait_rst_addr", {24'd0, reg_addr}, 0);
      check("wait_rst_wdata", reg_wdata, 0);
      check("wait_rst_m0_rdata", m0_rdata, 0);
      check("wait_rst_m1_rdata", m1_rdata, 0);
      rst    = 1'b0;
      m0_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_ack_after_rst", {30'd0, m0_ack, m1_ack}, 0);
      end
      set_master(0, 1'b1, 1'b0, 8'h44, 32'h0);
      set_master(1, 1'b1, 1'b0, 8'h48, 32'h0);
      serve(0, 1'b0, 8'h44, 32'h0, 0, 32'h0000_0044, 32'h0000_0044, 1'b0, 1, 3);
      m0_req = 1'b0;
      serve(1, 1'b0, 8'h48, 32'h0, 0, 32'h0000_0048, 32'h0000_0048, 1'b0, 2, 3);
      m1_req = 1'b0;
      tick();

      // back-to-back: m0 holds req for four transactions
      set_master(0, 1'b1, 1'b1, 8'h50, 32'h0000_BEEF);
      for (int i = 0; i < 4; i++) begin
         serve(0, 1'b1, 8'h50, 32'h0000_BEEF, i, 32'h100 + i, 32'h100 + i, 1'b0,
               (i == 0) ? 1 : 2, 3 + i);
      end
      m0_req = 1'b0;
      tick();
      check("b2b_idle_busy", {31'd0, busy}, 0);
      tick();
      check("b2b_no_extra_req", {31'd0, reg_req}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
